// File: rtl/e603_subsys_irq_pkg.sv
// Shared definitions for the peripheral IRQ conditioner: source indices and filter helpers.
package e603_subsys_irq_pkg;

  localparam int IRQ_NUM_DEF = 9;

  localparam int IRQ_UART0 = 0;
  localparam int IRQ_UDMA  = 1;
  localparam int IRQ_QSPI0 = 2;
  localparam int IRQ_QSPI1 = 3;
  localparam int IRQ_QSPI2 = 4;
  localparam int IRQ_MISC0 = 5;
  localparam int IRQ_MISC1 = 6;
  localparam int IRQ_ETH   = 7;
  localparam int IRQ_SDIO  = 8;

  // Filter counter must hold FILT_CYC itself; never let the width collapse to zero.
  function automatic int cnt_width(input int filt_cyc);
    return (filt_cyc < 1) ? 1 : $clog2(filt_cyc + 1);
  endfunction

endpackage

// File: rtl/e603_subsys_irq_filt.sv
// Per-source synchroniser chain followed by a stable-count glitch filter.
module e603_subsys_irq_filt
  import e603_subsys_irq_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYC    = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  output logic filt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {SYNC_STAGES{RST_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (FILT_CYC == 0) begin : g_bypass
    assign filt_o = sync_out;
  end else begin : g_filter
    localparam int CW = cnt_width(FILT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_out != filt_q) begin
        if (cnt_q == CW'(FILT_CYC - 1)) begin
          filt_d = sync_out;
          cnt_d  = '0;
        end else if (cnt_q != CW'(FILT_CYC)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q  <= '0;
        filt_q <= RST_VAL;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign filt_o = filt_q;
  end

endmodule

// File: rtl/e603_subsys_irq_cond.sv
// Conditions raw peripheral IRQs: sync, filter, polarity, level/edge capture, mask.
module e603_subsys_irq_cond
  import e603_subsys_irq_pkg::*;
#(
  parameter int                 IRQ_NUM     = IRQ_NUM_DEF,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 FILT_CYC    = 4,
  parameter logic [IRQ_NUM-1:0] IRQ_POL     = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irq_src_i,
  input  logic [IRQ_NUM-1:0] cfg_edge_i,
  input  logic [IRQ_NUM-1:0] irq_en_i,
  input  logic [IRQ_NUM-1:0] pend_clr_i,
  output logic [IRQ_NUM-1:0] irq_pend_o,
  output logic [IRQ_NUM-1:0] irq_out_o
);

  logic [IRQ_NUM-1:0] filt;
  logic [IRQ_NUM-1:0] act;
  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] prev_act_q;
  logic [IRQ_NUM-1:0] pend_q, pend_d;
  logic [IRQ_NUM-1:0] out_q, out_d;

  for (genvar g = 0; g < IRQ_NUM; g++) begin : g_src
    e603_subsys_irq_filt #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYC    (FILT_CYC),
      .RST_VAL     (IRQ_POL[g])
    ) u_filt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .src_i  (irq_src_i[g]),
      .filt_o (filt[g])
    );
  end

  assign act  = filt ^ IRQ_POL;
  assign rise = act & ~prev_act_q;

  // On a coincident rise and clear the rise term keeps the pending bit set.
  assign pend_d = (cfg_edge_i & (rise | (pend_q & ~pend_clr_i)))
                | (~cfg_edge_i & act);
  assign out_d  = pend_q & irq_en_i;

  // prev_act starts at 1 so a source already active out of reset is not seen as an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_act_q <= '1;
      pend_q     <= '0;
      out_q      <= '0;
    end else begin
      prev_act_q <= act;
      pend_q     <= pend_d;
      out_q      <= out_d;
    end
  end

  assign irq_pend_o = pend_q;
  assign irq_out_o  = out_q;

endmodule

// File: tb/tb_e603_subsys_irq_cond.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_e603_subsys_irq_cond;

  localparam logic [8:0] INACT = 9'h008;

  typedef struct {
    int         cyc;
    logic [8:0] mask;
    logic [8:0] pend;
    logic [8:0] out;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] src = INACT;
  logic [8:0] edge_cfg = 9'h004;
  logic [8:0] en = 9'h1ff;
  logic [8:0] clr = 9'h000;
  logic [8:0] pend;
  logic [8:0] out;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  e603_subsys_irq_cond #(
    .IRQ_NUM     (9),
    .SYNC_STAGES (2),
    .FILT_CYC    (4),
    .IRQ_POL     (9'h008)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_src_i  (src),
    .cfg_edge_i (edge_cfg),
    .irq_en_i   (en),
    .pend_clr_i (clr),
    .irq_pend_o (pend),
    .irq_out_o  (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dc, input logic [8:0] m, input logic [8:0] p,
                           input logic [8:0] o, input string nm);
    exp_t e;
    e.cyc = cyc + dc; e.mask = m; e.pend = p; e.out = o; e.name = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc <= cyc) begin
        checks++;
        if (q[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s stale expectation for cyc=%0d seen at cyc=%0d", q[i].name, q[i].cyc, cyc);
        end else if ((((pend ^ q[i].pend) | (out ^ q[i].out)) & q[i].mask) != 9'h000) begin
          errors++;
          $display("FAIL %s cyc=%0d pend=%b out=%b expected pend=%b out=%b mask=%b",
                   q[i].name, cyc, pend, out, q[i].pend, q[i].out, q[i].mask);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    int waited;
    // Reset held with random raw inputs
    tick(1);
    for (int i = 0; i < 4; i++) begin
      src = 9'($urandom);
      expect_at(0, 9'h1ff, 9'h000, 9'h000, "rst_hold");
      tick(1);
    end
    src = INACT;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) expect_at(i, 9'h1ff, 9'h000, 9'h000, "idle");
    tick(22);

    // Level mode latency on src0
    src[0] = 1'b1;
    expect_at(6, 9'h001, 9'h000, 9'h000, "lvl_pre");
    expect_at(7, 9'h001, 9'h001, 9'h000, "lvl_pend");
    expect_at(8, 9'h001, 9'h001, 9'h001, "lvl_out");
    tick(12);
    src[0] = 1'b0;
    expect_at(7, 9'h001, 9'h000, 9'h001, "lvl_fall_pre");
    expect_at(8, 9'h001, 9'h000, 9'h000, "lvl_fall");
    tick(12);

    // Glitch rejection on src1, then accepted 5-cycle pulse
    for (int i = 1; i < 15; i++) expect_at(i, 9'h002, 9'h000, 9'h000, "glitch3");
    src[1] = 1'b1;
    tick(3);
    src[1] = 1'b0;
    tick(12);
    expect_at(6, 9'h002, 9'h000, 9'h000, "pulse5_pre");
    expect_at(7, 9'h002, 9'h002, 9'h000, "pulse5_pend");
    expect_at(11, 9'h002, 9'h002, 9'h002, "pulse5_hold");
    expect_at(12, 9'h002, 9'h000, 9'h002, "pulse5_drop");
    expect_at(13, 9'h002, 9'h000, 9'h000, "pulse5_out_drop");
    src[1] = 1'b1;
    tick(5);
    src[1] = 1'b0;
    tick(12);

    // Edge capture on src2
    expect_at(6, 9'h004, 9'h000, 9'h000, "edge_pre");
    expect_at(7, 9'h004, 9'h004, 9'h000, "edge_pend");
    expect_at(8, 9'h004, 9'h004, 9'h004, "edge_out");
    src[2] = 1'b1;
    tick(6);
    src[2] = 1'b0;
    expect_at(14, 9'h004, 9'h004, 9'h004, "edge_hold");
    tick(16);
    clr[2] = 1'b1;
    expect_at(0, 9'h004, 9'h004, 9'h004, "clr_pre");
    expect_at(1, 9'h004, 9'h000, 9'h004, "clr_pend");
    expect_at(2, 9'h004, 9'h000, 9'h000, "clr_out");
    tick(1);
    clr[2] = 1'b0;
    tick(4);
    expect_at(6, 9'h004, 9'h000, 9'h000, "coin_pre");
    expect_at(7, 9'h004, 9'h004, 9'h000, "coin_set");
    expect_at(8, 9'h004, 9'h004, 9'h004, "coin_hold");
    src[2] = 1'b1;
    tick(6);
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    tick(4);
    src[2] = 1'b0;
    tick(8);

    // Active-low src3, then masking
    expect_at(0, 9'h008, 9'h000, 9'h000, "pol_idle");
    expect_at(6, 9'h008, 9'h000, 9'h000, "pol_pre");
    expect_at(7, 9'h008, 9'h008, 9'h000, "pol_pend");
    expect_at(8, 9'h008, 9'h008, 9'h008, "pol_out");
    src[3] = 1'b0;
    tick(10);
    en[3] = 1'b0;
    expect_at(0, 9'h008, 9'h008, 9'h008, "mask_pre");
    expect_at(1, 9'h008, 9'h008, 9'h000, "mask_off");
    expect_at(4, 9'h008, 9'h008, 9'h000, "mask_hold");
    tick(5);
    en[3] = 1'b1;
    expect_at(0, 9'h008, 9'h008, 9'h000, "unmask_pre");
    expect_at(1, 9'h008, 9'h008, 9'h008, "unmask");
    tick(3);

    // Async reset mid-filter with pending bits set
    src[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    expect_at(0, 9'h1ff, 9'h000, 9'h000, "async_rst");
    tick(1);
    src = INACT;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) expect_at(i, 9'h1ff, 9'h000, 9'h000, "post_rst");
    tick(16);

    waited = 0;
    while (q.size() > 0 && waited < 50) begin
      tick(1);
      waited++;
    end
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout expected at cyc=%0d not checked", q[0].name, q[0].cyc);
      void'(q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
